// File: rtl/td4_outport_monitor.sv
// Watches the TD4 output port and queues every value change with a timestamp.
// The host drains the queued events over a valid/ready handshake.
module td4_outport_monitor #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int TS_W   = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DATA_W-1:0]        port_in,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [TS_W+DATA_W-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = TS_W + DATA_W;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_n;
    logic [AW:0]       count_n;
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] prev;
    logic              first;
    logic              evt;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic [EW-1:0]     entry;

    assign rd_valid = (count != '0);

    always_comb begin
        evt      = en & (first | (port_in != prev));
        full     = (count == FULL_CNT);
        pop      = rd_valid & rd_ready;
        push     = evt & (~full | pop);
        drop     = evt & full & ~pop;
        entry    = {ts, port_in};
        rd_ptr_n = pop ? rd_ptr + 1'b1 : rd_ptr;
        count_n  = count + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            overflow <= 1'b0;
            ts       <= '0;
            prev     <= '0;
            first    <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            // Head register is preloaded so rd_data is a plain flop; a push
            // landing on the new head slot must bypass the memory read.
            if (count_n != '0) begin
                rd_data <= (push && (wr_ptr == rd_ptr_n)) ? entry : mem[rd_ptr_n];
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
            if (en) begin
                ts    <= ts + 1'b1;
                prev  <= port_in;
                first <= 1'b0;
            end
        end
    end

endmodule
